// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - fetch-to-decode instruction queue with NOP bubble on empty
// Circular buffer of {PC, instr, PC+4}; outputs are driven from registers only.
module fetch_decode_queue #(
  parameter int                WIDTH = 32,
  parameter int                DEPTH = 4,
  parameter logic [WIDTH-1:0]  NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       validF,
  input  logic [WIDTH-1:0]           PCF,
  input  logic [WIDTH-1:0]           instrF,
  input  logic [WIDTH-1:0]           PCPlus4F,
  output logic                       readyF,
  input  logic                       stallD,
  output logic                       validD,
  output logic [WIDTH-1:0]           PCD,
  output logic [WIDTH-1:0]           instrD,
  output logic [WIDTH-1:0]           PCPlus4D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] pc_q    [DEPTH];
  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [WIDTH-1:0] pc4_q   [DEPTH];

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign readyF = (count_q != CW'(DEPTH));
  assign validD = (count_q != '0);
  assign count  = count_q;

  // A flush cancels both sides of the handshake in the cycle it is raised.
  assign push = validF && readyF && !flush;
  assign pop  = validD && !stallD && !flush;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (rst || flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; stale entries are masked by count == 0.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_q[wr_q]    <= PCF;
      instr_q[wr_q] <= instrF;
      pc4_q[wr_q]   <= PCPlus4F;
    end
  end

  assign PCD      = validD ? pc_q[rd_q]    : '0;
  assign instrD   = validD ? instr_q[rd_q] : NOP;
  assign PCPlus4D = validD ? pc4_q[rd_q]   : '0;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - directed self-checking bench for fetch_decode_queue
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rst, flush, validF, stallD;
  logic [31:0] PCF, instrF, PCPlus4F;
  logic        readyF, validD;
  logic [31:0] PCD, instrD, PCPlus4D;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.WIDTH(32), .DEPTH(4), .NOP(32'h00000013)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .validF(validF), .PCF(PCF), .instrF(instrF), .PCPlus4F(PCPlus4F),
    .readyF(readyF), .stallD(stallD), .validD(validD),
    .PCD(PCD), .instrD(instrD), .PCPlus4D(PCPlus4D), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".validD"},   32'(validD), 32'd0);
    check({tag, ".instrD"},   instrD,      32'h00000013);
    check({tag, ".PCD"},      PCD,         32'd0);
    check({tag, ".PCPlus4D"}, PCPlus4D,    32'd0);
    check({tag, ".count"},    32'(count),  32'd0);
    check({tag, ".readyF"},   32'(readyF), 32'd1);
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc);
    validF   = v;
    PCF      = pc;
    instrF   = 32'hA000_0000 | pc;
    PCPlus4F = pc + 32'd4;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".validD"},   32'(validD), 32'd1);
    check({tag, ".PCD"},      PCD,         pc);
    check({tag, ".instrD"},   instrD,      32'hA000_0000 | pc);
    check({tag, ".PCPlus4D"}, PCPlus4D,    pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stallD = 1'b0;
    set_fetch(1'b0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    check_empty("reset");
    tick();
    check_empty("idle");

    // single push
    validF = 1'b1; PCF = 32'h100; instrF = 32'h00500093; PCPlus4F = 32'h104;
    tick();
    validF = 1'b0;
    check("single.validD",   32'(validD), 32'd1);
    check("single.PCD",      PCD,         32'h100);
    check("single.instrD",   instrD,      32'h00500093);
    check("single.PCPlus4D", PCPlus4D,    32'h104);
    check("single.count",    32'(count),  32'd1);
    tick();
    check_empty("single_drained");

    // fill while stalled; fifth push must be refused
    stallD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_fetch(1'b1, 32'(4 * i));
      tick();
      check("fill.count",  32'(count),  (i >= 3) ? 32'd4 : 32'(i + 1));
      check("fill.readyF", 32'(readyF), (i >= 3) ? 32'd0 : 32'd1);
    end
    set_fetch(1'b0, 32'd0);
    stallD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_head("drain", 32'(4 * k));
      tick();
    end
    check_empty("fill_drained");

    // steady push+pop at count 2 across the pointer wrap
    stallD = 1'b1;
    set_fetch(1'b1, 32'h200); tick();
    set_fetch(1'b1, 32'h204); tick();
    check("pp.count_pre", 32'(count), 32'd2);
    stallD = 1'b0;
    for (int j = 0; j < 8; j++) begin
      set_fetch(1'b1, 32'h208 + 32'(4 * j));
      check_head("pp", 32'h200 + 32'(4 * j));
      tick();
      check("pp.count", 32'(count), 32'd2);
    end
    set_fetch(1'b0, 32'd0);
    check_head("pp_tail0", 32'h220);
    tick();
    check_head("pp_tail1", 32'h224);
    tick();
    check_empty("pp_drained");

    // flush with count 3 and a simultaneous push
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 32'h300 + 32'(4 * i));
      tick();
    end
    check("flush.count_pre", 32'(count), 32'd3);
    flush = 1'b1;
    set_fetch(1'b1, 32'h30C);
    tick();
    flush = 1'b0;
    set_fetch(1'b0, 32'd0);
    stallD = 1'b0;
    check_empty("flush");
    tick();
    check_empty("flush_idle");
    set_fetch(1'b1, 32'h400);
    tick();
    set_fetch(1'b0, 32'd0);
    check_head("post_flush", 32'h400);
    check("post_flush.count", 32'(count), 32'd1);
    tick();
    check_empty("post_flush_drained");

    // reset mid-operation
    stallD = 1'b1;
    set_fetch(1'b1, 32'h500); tick();
    set_fetch(1'b1, 32'h504); tick();
    set_fetch(1'b0, 32'd0);
    check("rst.count_pre", 32'(count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.count",  32'(count),  32'd0);
    check("rst.readyF", 32'(readyF), 32'd1);
    check("rst.validD", 32'(validD), 32'd0);
    check("rst.instrD", instrD,      32'h00000013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised instruction queue between the fetch and decode stages, replacing the single-entry fetch/decode pipeline register. It buffers up to DEPTH fetched instructions with their PC and PC+4, lets fetch run ahead while decode stalls, and presents a NOP bubble (addi x0,x0,0) to decode whenever it is empty. A flush from branch/jump resolution discards every buffered entry in one cycle.

## Interface
- WIDTH, 32: data width of the instruction, PC and PC+4 fields.
- DEPTH, 4: number of entries; a power of two, at least 2.
- NOP, 32'h00000013: instruction word presented to decode when the queue is empty or has been flushed.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all entries; sampled on the rising edge.
- validF  in  1  fetch is presenting an instruction this cycle.
- PCF  in  WIDTH  PC of the fetched instruction.
- instrF  in  WIDTH  fetched instruction.
- PCPlus4F  in  WIDTH  PC+4 of the fetched instruction.
- readyF  out  1  queue can accept a push; equals count != DEPTH.
- stallD  in  1  decode is not consuming this cycle.
- validD  out  1  decode outputs hold a real instruction; equals count != 0.
- PCD  out  WIDTH  head-entry PC, or 0 when empty.
- instrD  out  WIDTH  head-entry instruction, or NOP when empty.
- PCPlus4D  out  WIDTH  head-entry PC+4, or 0 when empty.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage: DEPTH-entry circular buffer holding {PC, instr, PC+4}.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is kept as a separate register.
- Push: occurs when validF && readyF && !flush. The entry is written at the write pointer, and the write pointer increments.
  - If validF && !readyF, the input is ignored. Fetch must hold its PC.
- Pop: occurs when validD && !stallD && !flush. The read pointer increments.
- Same-cycle push and pop, with 0 < count < DEPTH: both happen and count is unchanged.
- Full (count == DEPTH):
  - readyF = 0, so no push is accepted even if a pop occurs that cycle. There is no full-queue pass-through.
  - A pop still occurs; readyF rises on the next cycle.
- Empty (count == 0):
  - validD = 0, instrD = NOP, PCD = 0, PCPlus4D = 0.
  - stallD is ignored.
  - A push in this cycle becomes visible on the next cycle. There is no bypass.
- Flush:
  - On the next edge, both pointers and count go to 0.
  - Any push or pop in the flush cycle is discarded.
  - flush has priority over stallD and validF.
- Reset: has the same effect as flush and takes priority over everything. Storage contents are not cleared; they are masked by count == 0.
- The stall input of the old register is replaced by the stallD and readyF pair. The hazard unit drives stallD and flush.

## Timing
- Reset values of outputs:
  - validD = 0, instrD = NOP, PCD = 0, PCPlus4D = 0.
  - count = 0, readyF = 1.
- Latency: an instruction pushed at edge N is presented on instrD from just after edge N, provided it is the head entry. This is one cycle, matching the old register.
- All outputs are functions of registers only; there is no combinational path from any input to any output.
  - readyF, validD and count come from count.
  - The D-side data is a mux of storage, indexed by the read pointer, gated by count != 0.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0, and order is preserved across the wrap.
- Reset or flush mid-operation: the next cycle reads empty, whatever the previous count or pointer positions were.

## Test plan
- Reset, then idle:
  - Required: validD = 0, instrD = 32'h00000013, PCD = 0, PCPlus4D = 0, readyF = 1, count = 0.
- Single push, stallD = 0: push {PC = 0x100, instr = 0x00500093, PC+4 = 0x104}.
  - Required next cycle: validD = 1 with exactly those values.
  - Required the cycle after: empty again.
- Fill while stalled: stallD = 1, push 5 consecutive instructions at PC 0x0, 0x4, 0x8, 0xC, 0x10.
  - Required: count reaches 4 and readyF = 0; the fifth push is ignored.
  - Then release stallD: decode sees PC 0x0, 0x4, 0x8, 0xC in consecutive cycles, then empty.
- Simultaneous push and pop with count = 2, held for 8 cycles:
  - Required: count stays 2, PCs come out strictly in order across the pointer wrap, and no entry is lost or duplicated.
- Flush with count = 3 and validF = 1 in the same cycle:
  - Required next cycle: count = 0, validD = 0, instrD = NOP.
  - The instruction pushed in the flush cycle never appears.
- Reset asserted with count = 2 during stallD = 1:
  - Required next cycle: count = 0, readyF = 1, validD = 0.
